// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
//
// Purpose:
//   Receive side of the two-channel ADC stream. Each accepted 32-bit beat is
//   unpacked into two signed 14-bit samples (RX channel, TX channel) and
//   registered. The block also provides:
//     - a block average of 2**LOG2_AVG samples per channel,
//     - sticky full-scale (overrange) flags,
//     - a watchdog that flags a stalled stream and drops the partial block.
//
// Parameters:
//   LOG2_AVG  log2 of samples per averaging block (0..8)
//   TIMEOUT   idle cycles without an accepted beat before LINK_LOST (2..65535)
//
// Ports:
//   clk                input   ADC clock, all logic on rising edge
//   rst                input   asynchronous, active-high reset
//   S_AXIS_ADC_tdata   input   [13:0] RX sample, [29:16] TX sample
//   S_AXIS_ADC_tvalid  input   beat valid
//   S_AXIS_ADC_tready  output  sink ready (1 from first edge after reset)
//   RX_ADC / TX_ADC    output  last accepted samples, signed
//   DATA_VALID         output  one-cycle pulse when RX_ADC/TX_ADC update
//   RX_AVG / TX_AVG    output  block averages, signed, floor rounding
//   AVG_VALID          output  one-cycle pulse when the averages update
//   OVR_CLR            input   clears both overrange flags
//   RX_OVR / TX_OVR    output  sticky full-scale flags
//   LINK_LOST          output  stream-idle watchdog flag
// ---------------------------------------------------------------------------
module adc_capture #(
    parameter int LOG2_AVG = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXIS_ADC_tdata,
    input  logic        S_AXIS_ADC_tvalid,
    output logic        S_AXIS_ADC_tready,
    output logic [13:0] RX_ADC,
    output logic [13:0] TX_ADC,
    output logic        DATA_VALID,
    output logic [13:0] RX_AVG,
    output logic [13:0] TX_AVG,
    output logic        AVG_VALID,
    input  logic        OVR_CLR,
    output logic        RX_OVR,
    output logic        TX_OVR,
    output logic        LINK_LOST
);

    localparam int SAMP_W = 14;
    // A full block of full-scale samples needs exactly LOG2_AVG extra bits.
    localparam int ACC_W  = SAMP_W + LOG2_AVG;
    localparam int CNT_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    localparam logic [SAMP_W-1:0] FS_POS = 14'h1FFF;
    localparam logic [SAMP_W-1:0] FS_NEG = 14'h2000;

    // -----------------------------------------------------------------------
    // Shared control
    // -----------------------------------------------------------------------
    logic              r_tready;
    logic              r_data_valid;
    logic              r_avg_valid;
    logic              r_link_lost;
    logic [CNT_W-1:0]  r_blk_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    logic              w_accept;
    logic              w_block_end;
    logic [IDLE_W-1:0] w_idle_next;
    logic              w_lost_rise;
    logic              w_unused_tdata;

    // Padding bits of the packed word are deliberately ignored.
    assign w_unused_tdata = ^{S_AXIS_ADC_tdata[31:30], S_AXIS_ADC_tdata[15:14]};

    assign w_accept    = S_AXIS_ADC_tvalid & r_tready;
    assign w_block_end = w_accept && (r_blk_cnt == CNT_LAST);

    always_comb begin
        w_idle_next = r_idle_cnt;
        if (w_accept) begin
            w_idle_next = '0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_next = r_idle_cnt + 1'b1;
        end
    end

    // Only the first cycle of a stall discards the partial block; once the
    // flag is up the accumulators are already empty.
    assign w_lost_rise = !r_link_lost && !w_accept && (w_idle_next == IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tready     <= 1'b0;
            r_data_valid <= 1'b0;
            r_avg_valid  <= 1'b0;
            r_link_lost  <= 1'b0;
            r_blk_cnt    <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_tready     <= 1'b1;
            r_data_valid <= w_accept;
            r_avg_valid  <= w_block_end;
            r_idle_cnt   <= w_idle_next;

            if (w_accept) begin
                r_link_lost <= 1'b0;
            end else if (w_idle_next == IDLE_MAX) begin
                r_link_lost <= 1'b1;
            end

            if (w_lost_rise) begin
                r_blk_cnt <= '0;
            end else if (w_accept) begin
                if (w_block_end) begin
                    r_blk_cnt <= '0;
                end else begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel datapath: channel 0 = RX (bits 13:0), 1 = TX (bits 29:16)
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic signed [SAMP_W-1:0] w_samp;
            logic signed [ACC_W-1:0]  w_ext;
            logic signed [ACC_W-1:0]  w_sum;
            logic signed [SAMP_W-1:0] w_avg;
            logic                     w_fullscale;

            logic signed [SAMP_W-1:0] r_samp;
            logic signed [ACC_W-1:0]  r_acc;
            logic signed [SAMP_W-1:0] r_avg;
            logic                     r_ovr;

            assign w_samp = S_AXIS_ADC_tdata[16*gi +: SAMP_W];
            assign w_ext  = ACC_W'(w_samp);
            assign w_sum  = r_acc + w_ext;
            // Dropping the low LOG2_AVG bits of a two's-complement sum is an
            // arithmetic shift with floor rounding.
            assign w_avg  = w_sum[ACC_W-1:LOG2_AVG];

            assign w_fullscale = (w_samp == FS_POS) || (w_samp == FS_NEG);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_samp <= '0;
                    r_acc  <= '0;
                    r_avg  <= '0;
                    r_ovr  <= 1'b0;
                end else begin
                    if (w_accept) begin
                        r_samp <= w_samp;
                    end

                    if (w_lost_rise) begin
                        r_acc <= '0;
                    end else if (w_accept) begin
                        if (w_block_end) begin
                            r_acc <= '0;
                            r_avg <= w_avg;
                        end else begin
                            r_acc <= w_sum;
                        end
                    end

                    // A new full-scale sample takes priority over a clear.
                    if (w_accept && w_fullscale) begin
                        r_ovr <= 1'b1;
                    end else if (OVR_CLR) begin
                        r_ovr <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign S_AXIS_ADC_tready = r_tready;
    assign DATA_VALID        = r_data_valid;
    assign AVG_VALID         = r_avg_valid;
    assign LINK_LOST         = r_link_lost;

    assign RX_ADC = gen_ch[0].r_samp;
    assign TX_ADC = gen_ch[1].r_samp;
    assign RX_AVG = gen_ch[0].r_avg;
    assign TX_AVG = gen_ch[1].r_avg;
    assign RX_OVR = gen_ch[0].r_ovr;
    assign TX_OVR = gen_ch[1].r_ovr;

endmodule

// File: tb/tb_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_capture
//
// Directed bench for adc_capture. Three instances share one stimulus:
//   u_dut4  LOG2_AVG=4, TIMEOUT=16  (main instance)
//   u_dut2  LOG2_AVG=2, TIMEOUT=16  (short-block averaging)
//   u_dut0  LOG2_AVG=0, TIMEOUT=16  (pass-through averaging)
// Each phase starts from a reset, so only the instance under test matters.
// ---------------------------------------------------------------------------
module tb_adc_capture;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        ovr_clr;

    logic        rdy4, dv4, av4, rxo4, txo4, ll4;
    logic [13:0] rx4, tx4, rxa4, txa4;
    logic        rdy2, dv2, av2, rxo2, txo2, ll2;
    logic [13:0] rx2, tx2, rxa2, txa2;
    logic        rdy0, dv0, av0, rxo0, txo0, ll0;
    logic [13:0] rx0, tx0, rxa0, txa0;

    int n_checks = 0;
    int n_errors = 0;
    int n_av4    = 0;
    int n_av2    = 0;
    int base;

    adc_capture #(.LOG2_AVG(4), .TIMEOUT(16)) u_dut4 (
        .clk(clk), .rst(rst),
        .S_AXIS_ADC_tdata(tdata), .S_AXIS_ADC_tvalid(tvalid), .S_AXIS_ADC_tready(rdy4),
        .RX_ADC(rx4), .TX_ADC(tx4), .DATA_VALID(dv4),
        .RX_AVG(rxa4), .TX_AVG(txa4), .AVG_VALID(av4),
        .OVR_CLR(ovr_clr), .RX_OVR(rxo4), .TX_OVR(txo4), .LINK_LOST(ll4)
    );

    adc_capture #(.LOG2_AVG(2), .TIMEOUT(16)) u_dut2 (
        .clk(clk), .rst(rst),
        .S_AXIS_ADC_tdata(tdata), .S_AXIS_ADC_tvalid(tvalid), .S_AXIS_ADC_tready(rdy2),
        .RX_ADC(rx2), .TX_ADC(tx2), .DATA_VALID(dv2),
        .RX_AVG(rxa2), .TX_AVG(txa2), .AVG_VALID(av2),
        .OVR_CLR(ovr_clr), .RX_OVR(rxo2), .TX_OVR(txo2), .LINK_LOST(ll2)
    );

    adc_capture #(.LOG2_AVG(0), .TIMEOUT(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .S_AXIS_ADC_tdata(tdata), .S_AXIS_ADC_tvalid(tvalid), .S_AXIS_ADC_tready(rdy0),
        .RX_ADC(rx0), .TX_ADC(tx0), .DATA_VALID(dv0),
        .RX_AVG(rxa0), .TX_AVG(txa0), .AVG_VALID(av0),
        .OVR_CLR(ovr_clr), .RX_OVR(rxo0), .TX_OVR(txo0), .LINK_LOST(ll0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count averaging pulses between edges so stray pulses are caught.
    always @(negedge clk) begin
        if (av4) n_av4 = n_av4 + 1;
        if (av2) n_av2 = n_av2 + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog sim_time_exceeded got=running exp=finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [13:0] rx, input logic [13:0] tx);
        tvalid = 1'b1;
        tdata  = {2'b00, tx, 2'b00, rx};
        tick();
        tvalid = 1'b0;
    endtask

    task automatic do_reset();
        tvalid  = 1'b0;
        ovr_clr = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] r;

        rst     = 1'b0;
        tvalid  = 1'b0;
        tdata   = '0;
        ovr_clr = 1'b0;

        // ---- Reset release and first beat ----
        #2;
        rst    = 1'b1;
        tvalid = 1'b1;
        tdata  = 32'h0ABC_1234;
        #10;
        check_val("rst_tready", 32'(rdy4), 32'h0);
        check_val("rst_rx",     32'(rx4),  32'h0);
        check_val("rst_dv",     32'(dv4),  32'h0);
        check_val("rst_lost",   32'(ll4),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("rel_tready", 32'(rdy4), 32'h1);
        check_val("rel_dv",     32'(dv4),  32'h0);
        tick();
        check_val("b1_rx",      32'(rx4),  32'h1234);
        check_val("b1_tx",      32'(tx4),  32'h0ABC);
        check_val("b1_dv",      32'(dv4),  32'h1);
        check_val("l0_avg",     32'(rxa0), 32'h1234);
        check_val("l0_avgv",    32'(av0),  32'h1);
        tvalid = 1'b0;
        tick();
        check_val("b1_dv_off",  32'(dv4),  32'h0);
        check_val("b1_rx_hold", 32'(rx4),  32'h1234);

        // ---- LOG2_AVG=2 with idle gaps ----
        do_reset();
        base = n_av2;
        beat(14'd4, 14'd0);
        check_val("l2_av_1", 32'(av2), 32'h0);
        beat(14'd8, 14'd0);
        check_val("l2_av_2", 32'(av2), 32'h0);
        tick();
        beat(14'h3FFC, 14'd0);
        check_val("l2_av_3", 32'(av2), 32'h0);
        repeat (2) tick();
        check_val("l2_dv_gap", 32'(dv2), 32'h0);
        beat(14'h3FFF, 14'd0);
        check_val("l2_dv_4",  32'(dv2),  32'h1);
        check_val("l2_av_4",  32'(av2),  32'h1);
        check_val("l2_rxavg", 32'(rxa2), 32'h0001);
        check_val("l2_txavg", 32'(txa2), 32'h0000);
        repeat (3) tick();
        check_val("l2_av_cnt", 32'(n_av2 - base), 32'd1);

        // ---- Full-scale block and overrange flags ----
        do_reset();
        base = n_av4;
        for (int i = 0; i < 15; i++) beat(14'h2000, 14'h1FFF);
        check_val("fs_av_15", 32'(av4), 32'h0);
        beat(14'h2000, 14'h1FFF);
        check_val("fs_av_16", 32'(av4),  32'h1);
        check_val("fs_rxavg", 32'(rxa4), 32'h2000);
        check_val("fs_txavg", 32'(txa4), 32'h1FFF);
        check_val("fs_rxovr", 32'(rxo4), 32'h1);
        check_val("fs_txovr", 32'(txo4), 32'h1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check_val("clr_rxovr", 32'(rxo4), 32'h0);
        check_val("clr_txovr", 32'(txo4), 32'h0);
        ovr_clr = 1'b1;
        beat(14'h2000, 14'h0000);
        ovr_clr = 1'b0;
        check_val("setwin_rxovr", 32'(rxo4), 32'h1);
        check_val("setwin_txovr", 32'(txo4), 32'h0);
        check_val("fs_av_cnt", 32'(n_av4 - base), 32'd1);

        // ---- Watchdog: stale partial block discarded ----
        do_reset();
        base = n_av4;
        for (int i = 0; i < 3; i++) beat(14'h0100, 14'h0100);
        repeat (15) tick();
        check_val("wd_lost_15", 32'(ll4), 32'h0);
        tick();
        check_val("wd_lost_16", 32'(ll4), 32'h1);
        for (int i = 0; i < 16; i++) begin
            beat(14'(i), 14'(-i));
            if (i == 0) check_val("wd_lost_clr", 32'(ll4), 32'h0);
        end
        check_val("wd_av",    32'(av4),  32'h1);
        check_val("wd_rxavg", 32'(rxa4), 32'h0007);
        check_val("wd_txavg", 32'(txa4), 32'h3FF8);
        tick();
        check_val("wd_av_cnt", 32'(n_av4 - base), 32'd1);

        // ---- Asynchronous reset mid-block ----
        do_reset();
        for (int i = 0; i < 5; i++) beat(14'h03E8, 14'h0000);
        check_val("mr_dv_pre", 32'(dv4), 32'h1);
        tvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_val("mr_tready", 32'(rdy4), 32'h0);
        check_val("mr_rx",     32'(rx4),  32'h0);
        check_val("mr_dv",     32'(dv4),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        base = n_av4;
        tick();
        check_val("mr_tready_up", 32'(rdy4), 32'h1);
        for (int i = 0; i < 15; i++) beat(14'h0020, 14'h3FE0);
        check_val("mr_av_15", 32'(av4), 32'h0);
        beat(14'h0020, 14'h3FE0);
        check_val("mr_av_16", 32'(av4),  32'h1);
        check_val("mr_rxavg", 32'(rxa4), 32'h0020);
        check_val("mr_txavg", 32'(txa4), 32'h3FE0);
        tick();
        check_val("mr_av_cnt", 32'(n_av4 - base), 32'd1);

        // ---- Padding bits toggled ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            r      = $urandom;
            tvalid = 1'b1;
            tdata  = {r[1:0], 14'h3E00, r[3:2], 14'h0123};
            tick();
            check_val("pad_rx", 32'(rx4), 32'h0123);
            check_val("pad_tx", 32'(tx4), 32'h3E00);
        end
        tvalid = 1'b0;
        check_val("pad_av",    32'(av4),  32'h1);
        check_val("pad_rxavg", 32'(rxa4), 32'h0123);
        check_val("pad_txavg", 32'(txa4), 32'h3E00);
        check_val("pad_rxovr", 32'(rxo4), 32'h0);
        check_val("pad_txovr", 32'(txo4), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart to the DAC packing block: accepts the packed two-channel ADC AXI-Stream word, unpacks it into two signed 14-bit samples (RX channel, TX channel) and registers them.
- Produces per-sample outputs, a block-averaged (decimated) output, sticky overrange flags and a stream-loss watchdog.
- Sits between the ADC AXI-Stream source and the phase-detection / servo logic, in the 125 MHz ADC clock domain.

Parameters:
- LOG2_AVG, 4, log2 of samples per averaging block; legal range 0..8.
- TIMEOUT, 16, idle cycles without an accepted beat before LINK_LOST asserts; legal range 2..65535.

Ports:
- clk  input  1  ADC clock, 125 MHz; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- S_AXIS_ADC_tdata  input  32  packed word: [13:0] RX sample, [29:16] TX sample, two's complement; [15:14] and [31:30] ignored.
- S_AXIS_ADC_tvalid  input  1  beat valid.
- S_AXIS_ADC_tready  output  1  sink ready.
- RX_ADC  output  14  last accepted RX sample, signed.
- TX_ADC  output  14  last accepted TX sample, signed.
- DATA_VALID  output  1  one-cycle pulse when RX_ADC/TX_ADC update.
- RX_AVG  output  14  block average of RX, signed.
- TX_AVG  output  14  block average of TX, signed.
- AVG_VALID  output  1  one-cycle pulse when RX_AVG/TX_AVG update.
- OVR_CLR  input  1  clears both overrange flags.
- RX_OVR  output  1  sticky: RX sample hit full scale.
- TX_OVR  output  1  sticky: TX sample hit full scale.
- LINK_LOST  output  1  stream-idle watchdog flag.

Behaviour:
- Reset, asynchronous: all outputs 0, including tready. Accumulators, block counter and idle counter are cleared.
- tready is a register. It is 0 while rst is asserted, goes to 1 on the first clk edge after rst deasserts, and then stays 1. There is no backpressure.
- Accept means tvalid & tready at a rising edge.
- Sample path: on accept, RX_ADC <= tdata[13:0] and TX_ADC <= tdata[29:16]; DATA_VALID is 1 in the following cycle (latency 1). With no accept, DATA_VALID is 0 and the samples hold their values.
- Averaging:
  - Per channel: signed accumulator of width 14+LOG2_AVG, plus a shared block counter of width max(LOG2_AVG,1).
  - On each accept, the sample is sign-extended and added, and the counter increments.
  - On the accept where counter == 2^LOG2_AVG-1: AVG <= (acc + sample) >>> LOG2_AVG (arithmetic shift, floor rounding). The accumulator and counter then go to 0. AVG_VALID pulses in the same cycle as that sample's DATA_VALID.
  - Full-scale sums must not overflow.
  - LOG2_AVG = 0: AVG equals each sample, and AVG_VALID equals DATA_VALID.
- Overrange:
  - On accept, an RX sample equal to 14'h1FFF or 14'h2000 sets RX_OVR on the next edge; the same rule applies to TX.
  - OVR_CLR high at an edge clears both flags.
  - Set and clear in the same cycle: the set wins.
- Watchdog:
  - The idle counter resets to 0 on accept; otherwise it increments, saturating at TIMEOUT.
  - LINK_LOST <= 1 when the counter reaches TIMEOUT, i.e. the TIMEOUT-th consecutive cycle without accept.
  - On the LINK_LOST rising transition, the accumulators and block counter are cleared and the partial block is discarded. No AVG_VALID is produced.
  - LINK_LOST <= 0 on the edge of the next accept. That beat is processed normally and starts a fresh block.
- Reset mid-block: the partial block is discarded, and the first block after reset is a full 2^LOG2_AVG samples.
- Sign handling: all arithmetic is signed two's complement; the ignored tdata bits never affect any output.

Test Plan:
- Reset release, tvalid=1, tdata=32'h0ABC_1234 -> tready=1 one edge after release; RX_ADC=14'h1234, TX_ADC=14'h0ABC, DATA_VALID single pulse one cycle after the accept.
- LOG2_AVG=2; RX samples 4, 8, 14'h3FFC(-4), 14'h3FFF(-1), with gaps of 0 to 3 idle cycles (below TIMEOUT) -> exactly one AVG_VALID, coincident with the 4th DATA_VALID, RX_AVG=1 (sum 7 >>> 2).
- LOG2_AVG=4; 16 beats of RX=14'h2000, TX=14'h1FFF -> RX_AVG=14'h2000, TX_AVG=14'h1FFF (no overflow); RX_OVR=TX_OVR=1. OVR_CLR pulse with no beat -> both 0. OVR_CLR coincident with an overrange beat -> flag stays 1.
- TIMEOUT=16; stop tvalid after 3 of 16 beats -> LINK_LOST rises on the 16th idle cycle. Next beat clears it. The following 16 beats give one AVG_VALID; the 3 stale samples are excluded from the average.
- Assert rst mid-block (after 5 of 16 beats) with tvalid=1 -> all outputs 0 immediately (asynchronously) and tready=0. After release, the first AVG_VALID comes only after 16 new accepts.
- tdata upper bits [15:14] and [31:30] toggled randomly with fixed samples -> RX_ADC, TX_ADC, averages and flags are unchanged.
